// File: rtl/apb_regfield_ctrl.sv
// APB slave front-end for a bank of regfield slots: decodes the word index, issues one-cycle
// write/read strobes and returns registered read data and error status.
module apb_regfield_ctrl #(
  parameter int unsigned        REG_NUM    = 8,
  parameter int unsigned        ADDR_WIDTH = 12,
  parameter int unsigned        DATA_WIDTH = 32,
  parameter int unsigned        WAIT_CYC   = 0,
  parameter logic [REG_NUM-1:0] RO_MASK    = '0,
  parameter logic [REG_NUM-1:0] WO_MASK    = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          apb_psel_i,
  input  logic                          apb_penable_i,
  input  logic                          apb_pwrite_i,
  input  logic [ADDR_WIDTH-1:0]         apb_paddr_i,
  input  logic [DATA_WIDTH-1:0]         apb_pwdata_i,
  output logic                          apb_pready_o,
  output logic [DATA_WIDTH-1:0]         apb_prdata_o,
  output logic                          apb_pslverr_o,
  output logic [REG_NUM-1:0]            reg_wen_o,
  output logic [REG_NUM-1:0]            reg_ren_o,
  output logic [DATA_WIDTH-1:0]         reg_wdata_o,
  input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rdata_i
);

  localparam int unsigned IdxW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            cnt_q, cnt_d;

  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [REG_NUM-1:0]    wen_q, wen_d;
  logic [REG_NUM-1:0]    ren_q, ren_d;
  logic [DATA_WIDTH-1:0] rwdata_q, rwdata_d;

  logic [IdxW-1:0]       addr_idx;
  logic                  ro_hit;
  logic                  wo_hit;
  logic [REG_NUM-1:0]    slot_sel;
  logic [DATA_WIDTH-1:0] rd_slot;
  logic                  resp_load;
  logic                  unused_paddr;

  // Byte lanes are ignored: only whole-word accesses exist.
  assign unused_paddr = ^apb_paddr_i[1:0];
  assign addr_idx     = apb_paddr_i[ADDR_WIDTH-1:2];

  always_comb begin
    ro_hit   = 1'b0;
    slot_sel = '0;
    rd_slot  = '0;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      if (addr_idx == IdxW'(i)) ro_hit = RO_MASK[i];
      slot_sel[i] = (idx_q == IdxW'(i));
      if (slot_sel[i]) rd_slot = reg_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
    wo_hit = |(slot_sel & WO_MASK);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (apb_psel_i && !apb_penable_i) state_d = StWait;
      StWait: begin
        if (!apb_psel_i)                             state_d = StIdle;
        else if (apb_penable_i && cnt_q == 4'd0)     state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (state_q == StIdle && state_d == StWait) begin
      write_d = apb_pwrite_i;
      idx_d   = addr_idx;
      wdata_d = apb_pwdata_i;
      err_d   = (addr_idx >= IdxW'(REG_NUM)) || (apb_pwrite_i && ro_hit);
      cnt_d   = 4'(WAIT_CYC);
    end else if (state_q == StWait && apb_psel_i && apb_penable_i && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign resp_load = (state_q == StWait) && (state_d == StResp);

  // Response registers are pulses: loaded on entry to RESP, cleared every other cycle.
  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    wen_d     = '0;
    ren_d     = '0;
    rwdata_d  = '0;
    if (resp_load) begin
      pready_d  = 1'b1;
      pslverr_d = err_q;
      if (!err_q) begin
        if (write_q) begin
          wen_d    = slot_sel;
          rwdata_d = wdata_q;
        end else begin
          ren_d    = slot_sel;
          prdata_d = wo_hit ? '0 : rd_slot;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wen_q     <= '0;
      ren_q     <= '0;
      rwdata_q  <= '0;
    end else begin
      write_q   <= write_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      rwdata_q  <= rwdata_d;
    end
  end

  assign apb_pready_o  = pready_q;
  assign apb_pslverr_o = pslverr_q;
  assign apb_prdata_o  = prdata_q;
  assign reg_wen_o     = wen_q;
  assign reg_ren_o     = ren_q;
  assign reg_wdata_o   = rwdata_q;

endmodule

// File: tb/tb_apb_regfield_ctrl.sv
// Bench for apb_regfield_ctrl: two instances (no wait states / three wait states) sharing one
// bus and a small regfield model; expected responses are queued at drive time.
module tb_apb_regfield_ctrl;

  localparam logic [7:0] RoMask = 8'b0000_0010;
  localparam logic [7:0] WoMask = 8'b1000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         psel0 = 1'b0, psel1 = 1'b0;
  logic         penable = 1'b0, pwrite = 1'b0;
  logic [11:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic [255:0] reg_rdata;

  logic        pready0, pready1, pslverr0, pslverr1;
  logic [31:0] prdata0, prdata1, wdata0, wdata1;
  logic [7:0]  wen0, wen1, ren0, ren1;

  logic        dsel = 1'b0;
  logic        pready, pslverr;
  logic [31:0] prdata, wdata;
  logic [7:0]  wen, ren;

  logic [31:0] mem [8];
  logic [31:0] shadow [8];

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [7:0]  wen;
    logic [7:0]  ren;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  apb_regfield_ctrl #(
    .REG_NUM(8), .ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYC(0),
    .RO_MASK(RoMask), .WO_MASK(WoMask)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .apb_psel_i(psel0), .apb_penable_i(penable),
    .apb_pwrite_i(pwrite), .apb_paddr_i(paddr), .apb_pwdata_i(pwdata),
    .apb_pready_o(pready0), .apb_prdata_o(prdata0), .apb_pslverr_o(pslverr0),
    .reg_wen_o(wen0), .reg_ren_o(ren0), .reg_wdata_o(wdata0), .reg_rdata_i(reg_rdata)
  );

  apb_regfield_ctrl #(
    .REG_NUM(8), .ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYC(3),
    .RO_MASK(RoMask), .WO_MASK(WoMask)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .apb_psel_i(psel1), .apb_penable_i(penable),
    .apb_pwrite_i(pwrite), .apb_paddr_i(paddr), .apb_pwdata_i(pwdata),
    .apb_pready_o(pready1), .apb_prdata_o(prdata1), .apb_pslverr_o(pslverr1),
    .reg_wen_o(wen1), .reg_ren_o(ren1), .reg_wdata_o(wdata1), .reg_rdata_i(reg_rdata)
  );

  always_comb begin
    pready  = dsel ? pready1  : pready0;
    pslverr = dsel ? pslverr1 : pslverr0;
    prdata  = dsel ? prdata1  : prdata0;
    wdata   = dsel ? wdata1   : wdata0;
    wen     = dsel ? wen1     : wen0;
    ren     = dsel ? ren1     : ren0;
  end

  function automatic logic [31:0] init_val(input int i);
    if (i == 3) return 32'h1234_5678;
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Regfield model: slots take write data on the strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst)          mem[i] <= init_val(i);
      else if (wen0[i]) mem[i] <= wdata0;
      else if (wen1[i]) mem[i] <= wdata1;
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < 8; i++) reg_rdata[i*32 +: 32] = mem[i];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic reset_shadow();
    for (int i = 0; i < 8; i++) shadow[i] = init_val(i);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  // One APB transfer; drop_at > 0 lowers penable during that access cycle.
  task automatic xfer(input logic d, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wd, input int drop_at);
    exp_t e;
    int   idx;
    int   lat;
    bit   got;
    idx     = int'(addr[11:2]);
    e.wr    = wr;
    e.err   = (idx >= 8) || (wr && idx < 8 && RoMask[idx[2:0]]);
    e.wen   = '0;
    e.ren   = '0;
    e.rdata = '0;
    e.wdata = wd;
    e.lat   = 2 + (d ? 3 : 0) + (drop_at > 0 ? 1 : 0);
    if (!e.err) begin
      if (wr) begin
        e.wen       = 8'(1 << idx);
        shadow[idx] = wd;
      end else begin
        e.ren   = 8'(1 << idx);
        e.rdata = WoMask[idx[2:0]] ? 32'h0 : shadow[idx];
      end
    end
    sb_q.push_back(e);
    dsel = d;
    @(posedge clk); #1;
    psel0 = !d; psel1 = d; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    check("setup_quiet", {pready, wen, ren}, '0);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      penable = (k == drop_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (pready) begin
        got = 1'b1;
        lat = k;
      end else begin
        check("wait_quiet", {wen, ren}, '0);
      end
    end
    e = sb_q.pop_front();
    if (!got) begin
      check("timeout", 64'd0, 64'd1);
    end else begin
      check("latency", 64'(lat), 64'(e.lat));
      check("pslverr", 64'(pslverr), 64'(e.err));
      check("wen", 64'(wen), 64'(e.wen));
      check("ren", 64'(ren), 64'(e.ren));
      if (!e.wr || e.err) check("prdata", 64'(prdata), 64'(e.rdata));
      if (e.wr && !e.err) check("wdata", 64'(wdata), 64'(e.wdata));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {pready0, pslverr0, wen0, ren0, prdata0 | wdata0}, '0);
    check(tag, {pready1, pslverr1, wen1, ren1, prdata1 | wdata1}, '0);
  endtask

  initial begin
    reset_shadow();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outs");

    // No wait states.
    xfer(1'b0, 1'b1, 12'h008, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 1'b0, 12'h00C, 32'h0, 0);
    xfer(1'b0, 1'b0, 12'h020, 32'h0, 0);
    xfer(1'b0, 1'b1, 12'h004, 32'h1111_2222, 0);
    xfer(1'b0, 1'b0, 12'h01C, 32'h0, 0);
    xfer(1'b0, 1'b1, 12'h000, 32'hCAFE_F00D, 0);
    xfer(1'b0, 1'b0, 12'h000, 32'h0, 0);
    xfer(1'b0, 1'b0, 12'h00B, 32'h0, 0);
    xfer(1'b0, 1'b1, 12'h3FC, 32'h5555_AAAA, 0);
    idle();

    // Three wait states, including a one-cycle penable drop.
    xfer(1'b1, 1'b1, 12'h010, 32'h0BAD_CAFE, 0);
    xfer(1'b1, 1'b0, 12'h010, 32'h0, 0);
    xfer(1'b1, 1'b0, 12'h014, 32'h0, 2);
    idle();

    // psel abort in WAIT: no response, then a normal transfer.
    dsel = 1'b1;
    @(posedge clk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'h7777_7777;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel1 = 1'b0; penable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_quiet", {pready1, wen1, ren1}, '0);
    end
    xfer(1'b1, 1'b0, 12'h018, 32'h0, 0);
    idle();

    // Reset during WAIT drops the in-flight write.
    @(posedge clk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h9999_0000;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; psel1 = 1'b0; penable = 1'b0;
    reset_shadow();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_all_zero("rst_quiet");
    end
    xfer(1'b1, 1'b0, 12'h014, 32'h0, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
